stopwatch_core: RTL and testbench
=================================

# stopwatch_core

Parametrised stopwatch timekeeping core with run/pause/clear control, lap freeze, and in-place minute/second adjustment. It replaces the separate arbiter, paused and counting blocks in the stopwatch top level. It sits between the input debouncers (it consumes single-cycle pulses and levels) and the display controller. Its time value is kept directly in BCD, so no divide/modulo logic is needed downstream.

## Interface
Parameters:
- CLK_HZ, default 100_000_000: input clock frequency. One second is exactly CLK_HZ cycles. Must be ≥ 8.
- ADJ_HZ, default 2: increment rate in adjust mode. Must satisfy 1 ≤ ADJ_HZ ≤ CLK_HZ/4.
- MIN_MAX, default 59: highest minute value before wrap. Range 1..99.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset. Assertion takes effect immediately; deassertion is synchronised internally to clk.
- start_stop  in  1  single-cycle pulse (debounced); toggles run/pause.
- lap  in  1  single-cycle pulse; toggles the display freeze.
- clear  in  1  single-cycle pulse; zeroes the count when paused.
- sel  in  1  level: 0 = adjust minutes, 1 = adjust seconds.
- adj  in  1  level: 1 = adjust mode.
- min_tens, min_units, sec_tens, sec_units  out  4 each  displayed time in BCD.
- running  out  1  high in RUN.
- frozen  out  1  high while the lap freeze is active.
- blink_mask  out  4  per-digit blank request, bit order {min_tens, min_units, sec_tens, sec_units}.
- tick  out  1  one-cycle pulse on every live-count change.

## Operation
- State machine with four states:
  - IDLE: stopped, count is zero.
  - RUN: live count advances.
  - PAUSE: stopped, count is held.
  - ADJUST: count is edited.
- Reset → IDLE. All outputs are 0: count 00:00, running=0, frozen=0, blink_mask=0, tick=0. The prescaler and adjust timer are cleared.
- Event priority when events coincide in one cycle: adj > clear > start_stop > lap. Only the highest-priority applicable event acts; lower-priority events in that cycle are dropped.
- IDLE:
  - start_stop → RUN.
  - adj=1 → ADJUST.
  - clear and lap are ignored.
- RUN:
  - start_stop → PAUSE.
  - adj=1 → ADJUST.
  - lap toggles frozen.
  - clear is ignored.
- PAUSE:
  - start_stop → RUN.
  - clear → IDLE. Zeroes the count and prescaler, and sets frozen=0.
  - adj=1 → ADJUST.
  - lap toggles frozen.
- ADJUST:
  - adj=0 → PAUSE.
  - start_stop, lap and clear are ignored.
  - Entry sets frozen=0.
- Live count is seconds 0..59 and minutes 0..MIN_MAX, both in BCD.
  - Carry: sec 59 → 00 and minutes +1.
  - Wrap: MIN_MAX:59 → 00:00; counting continues.
- Prescaler:
  - Counts CLK_HZ cycles while in RUN.
  - Holds its value in PAUSE and ADJUST, so a partial second is preserved.
  - Cleared in IDLE.
- ADJUST increments the selected field every CLK_HZ/ADJ_HZ cycles, with no carry between fields:
  - seconds wrap 59 → 00;
  - minutes wrap MIN_MAX → 00.
  - The adjust timer restarts on ADJUST entry and on any change of sel.
- Lap freeze:
  - On set, the current live count is captured and the digit outputs show the capture.
  - The live count keeps running underneath.
  - On release, the digit outputs return to the live count.
- blink_mask:
  - In ADJUST, the two bits of the selected field toggle every CLK_HZ/4 cycles, starting at 1 on entry.
  - The other two bits are 0.
  - Outside ADJUST, all bits are 0.

## Timing
- All outputs are registered.
- An event sampled at edge N produces its state change and output change at edge N+1. Example: running rises one cycle after the start_stop pulse.
- From IDLE, the first RUN tick occurs exactly CLK_HZ cycles after running rises. tick and the updated digits appear in the same cycle.
- tick also pulses on each ADJUST increment. tick does not pulse when frozen output changes.
- Reset mid-operation: all state is abandoned immediately and the block returns to IDLE with zero count.
- adj asserted on the same edge as a RUN second boundary: ADJUST wins, and that second is not counted.

## Configuration
- STOPWATCH_LAP_EN:
  - Defined: lap freeze as described above.
  - Undefined: lap is ignored, frozen is tied to 0, the capture registers are absent, and the digit outputs always show the live count.

## Test plan
Bench parameters: CLK_HZ=8, ADJ_HZ=2, MIN_MAX=59.
- Run from reset: release reset, pulse start_stop → running=1 next cycle; tick every 8 cycles; after 8×75 cycles digits read 01:15.
- Wrap: adjust to 59:59, leave adjust (PAUSE), pulse start_stop → after 8 cycles digits read 00:00 with a tick pulse, running stays 1.
- Pause and clear: run to 00:03 plus 5 cycles, pause, wait 100 cycles, resume → 00:04 after exactly 3 more cycles. Pause again, clear → IDLE, 00:00, running=0.
- Lap: run to 00:05, pulse lap → digits hold 00:05 with frozen=1. After 16 cycles pulse lap → digits show 00:07 and frozen=0. Without STOPWATCH_LAP_EN, digits never freeze.
- Adjust: adj=1, sel=0 → minutes +1 every 4 cycles, blink_mask toggles 1100/0000 every 2 cycles. Set sel=1 → seconds advance 58 → 59 → 00 with minutes unchanged.
- Priority and reset: adj and start_stop in the same cycle while in PAUSE → ADJUST, running=0. Assert reset during RUN at 00:09 → all outputs 0 immediately.

Source files
------------

// File: rtl/stopwatch_core.sv
`default_nettype none
// ============================================================================
// stopwatch_core: BCD stopwatch core with run/pause/clear, adjust and lap.
// Lap freeze is built only when STOPWATCH_LAP_EN is defined.       Rev 1.0
// ============================================================================
module stopwatch_core #(
  parameter int CLK_HZ  = 100_000_000,
  parameter int ADJ_HZ  = 2,
  parameter int MIN_MAX = 59
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic       sel,
  input  logic       adj,
  output logic [3:0] min_tens,
  output logic [3:0] min_units,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_units,
  output logic       running,
  output logic       frozen,
  output logic [3:0] blink_mask,
  output logic       tick
);

  localparam int CW = $clog2(CLK_HZ);
  localparam logic [CW-1:0] c_PRE_LAST = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] c_ADJ_LAST = CW'(CLK_HZ / ADJ_HZ - 1);
  localparam logic [CW-1:0] c_BLK_LAST = CW'(CLK_HZ / 4 - 1);
  localparam logic [7:0]    c_MIN_BCD  = {4'(MIN_MAX / 10), 4'(MIN_MAX % 10)};
  localparam logic [7:0]    c_SEC_BCD  = 8'h59;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_ADJUST} state_t;

  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] last);
    if (v == last) return 8'h00;
    if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

  // Assertion is immediate; release reaches the core only after two clk edges.
  logic [1:0] rst_sync_q;
  logic       rst_n;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  state_t        state_q, state_d;
  logic [CW-1:0] presc_q, presc_d, adjt_q, adjt_d, blkt_q, blkt_d;
  logic          blk_ph_q, blk_ph_d;
  logic          sel_q;
  logic [15:0]   count_q, count_d;
  logic [15:0]   disp_q, disp_d;
  logic          running_q, tick_q, tick_d;
  logic [3:0]    mask_q, mask_d;
  logic          lap_ev, unfreeze;

  always_comb begin
    state_d  = state_q;
    presc_d  = presc_q;
    adjt_d   = adjt_q;
    blkt_d   = blkt_q;
    blk_ph_d = blk_ph_q;
    count_d  = count_q;
    tick_d   = 1'b0;
    lap_ev   = 1'b0;
    unfreeze = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (adj)             state_d = S_ADJUST;
        else if (start_stop) state_d = S_RUN;
      end
      S_RUN: begin
        if (adj)             state_d = S_ADJUST;
        else if (start_stop) state_d = S_PAUSE;
        else begin
          lap_ev = lap;
          if (presc_q == c_PRE_LAST) begin
            presc_d       = '0;
            tick_d        = 1'b1;
            count_d[7:0]  = bcd_inc(count_q[7:0], c_SEC_BCD);
            if (count_q[7:0] == c_SEC_BCD)
              count_d[15:8] = bcd_inc(count_q[15:8], c_MIN_BCD);
          end else begin
            presc_d = presc_q + CW'(1);
          end
        end
      end
      S_PAUSE: begin
        if (adj) state_d = S_ADJUST;
        else if (clear) begin
          state_d  = S_IDLE;
          count_d  = '0;
          presc_d  = '0;
          unfreeze = 1'b1;
        end
        else if (start_stop) state_d = S_RUN;
        else                 lap_ev  = lap;
      end
      S_ADJUST: begin
        if (!adj) state_d = S_PAUSE;
        else begin
          if (blkt_q == c_BLK_LAST) begin
            blkt_d   = '0;
            blk_ph_d = ~blk_ph_q;
          end else begin
            blkt_d = blkt_q + CW'(1);
          end
          // A field switch restarts the increment period for the new field.
          if (sel != sel_q) adjt_d = '0;
          else if (adjt_q == c_ADJ_LAST) begin
            adjt_d = '0;
            tick_d = 1'b1;
            if (sel) count_d[7:0]  = bcd_inc(count_q[7:0], c_SEC_BCD);
            else     count_d[15:8] = bcd_inc(count_q[15:8], c_MIN_BCD);
          end else begin
            adjt_d = adjt_q + CW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d == S_ADJUST && state_q != S_ADJUST) begin
      adjt_d   = '0;
      blkt_d   = '0;
      blk_ph_d = 1'b1;
      unfreeze = 1'b1;
    end
    mask_d = (state_d == S_ADJUST && blk_ph_d) ? (sel ? 4'b0011 : 4'b1100) : 4'b0000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      adjt_q    <= '0;
      blkt_q    <= '0;
      blk_ph_q  <= 1'b0;
      sel_q     <= 1'b0;
      count_q   <= '0;
      disp_q    <= '0;
      running_q <= 1'b0;
      tick_q    <= 1'b0;
      mask_q    <= '0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      adjt_q    <= adjt_d;
      blkt_q    <= blkt_d;
      blk_ph_q  <= blk_ph_d;
      sel_q     <= sel;
      count_q   <= count_d;
      disp_q    <= disp_d;
      running_q <= (state_d == S_RUN);
      tick_q    <= tick_d;
      mask_q    <= mask_d;
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic        frozen_q, frozen_d;
  logic [15:0] cap_q, cap_d;

  always_comb begin
    frozen_d = frozen_q;
    cap_d    = cap_q;
    if (unfreeze) frozen_d = 1'b0;
    else if (lap_ev) begin
      frozen_d = ~frozen_q;
      if (!frozen_q) cap_d = count_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frozen_q <= 1'b0;
      cap_q    <= '0;
    end else begin
      frozen_q <= frozen_d;
      cap_q    <= cap_d;
    end
  end

  assign disp_d = frozen_d ? cap_d : count_d;
  assign frozen = frozen_q;
`else
  logic unused_lap;
  assign unused_lap = lap_ev ^ unfreeze;
  assign disp_d     = count_d;
  assign frozen     = 1'b0;
`endif

  assign {min_tens, min_units, sec_tens, sec_units} = disp_q;
  assign running    = running_q;
  assign tick       = tick_q;
  assign blink_mask = mask_q;

endmodule
`default_nettype wire

// File: tb/tb_stopwatch_core.sv
`default_nettype none
// ============================================================================
// tb_stopwatch_core: directed self-checking bench for stopwatch_core.
// Rev 1.0
// ============================================================================
module tb_stopwatch_core;

`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic       sel = 1'b0;
  logic       adj = 1'b0;
  logic [3:0] min_tens, min_units, sec_tens, sec_units;
  logic       running, frozen, tick;
  logic [3:0] blink_mask;
  logic [15:0] disp;

  int n_chk = 0;
  int n_err = 0;

  stopwatch_core #(.CLK_HZ(8), .ADJ_HZ(2), .MIN_MAX(59)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_stop (start_stop),
    .lap        (lap),
    .clear      (clear),
    .sel        (sel),
    .adj        (adj),
    .min_tens   (min_tens),
    .min_units  (min_units),
    .sec_tens   (sec_tens),
    .sec_units  (sec_units),
    .running    (running),
    .frozen     (frozen),
    .blink_mask (blink_mask),
    .tick       (tick)
  );

  always #5 clk = ~clk;
  assign disp = {min_tens, min_units, sec_tens, sec_units};

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0 = start_stop, 1 = lap, 2 = clear; one cycle wide, sampled on the next edge
  task automatic pulse(input int k);
    case (k)
      0: start_stop = 1'b1;
      1: lap        = 1'b1;
      default: clear = 1'b1;
    endcase
    @(negedge clk);
    start_stop = 1'b0;
    lap        = 1'b0;
    clear      = 1'b0;
  endtask

  initial begin
    step(3);
    chk("rst_digits", disp, 16'h0000);
    chk("rst_flags", {12'd0, running, frozen, tick, 1'b0}, 16'h0000);
    chk("rst_mask", {12'd0, blink_mask}, 16'h0000);
    reset = 1'b1;
    step(4);
    pulse(2);
    pulse(1);
    chk("idle_ignore", {disp[11:0], running, frozen, tick, 1'b0}, 16'h0000);

    // run from IDLE: first tick 8 cycles after running rises
    pulse(0);
    chk("run_rise", {12'd0, running, tick, 2'b00}, 16'h0008);
    step(7);
    chk("tick_pre", {15'd0, tick}, 16'h0000);
    step(1);
    chk("tick_1s", {disp[14:0], tick}, {15'h0001, 1'b1});
    step(592);
    chk("run_0115", disp, 16'h0115);
    chk("tick_600", {15'd0, tick}, 16'h0001);

    pulse(0);
    chk("pause_hold", {disp[14:0], running}, {15'h0115, 1'b0});
    pulse(2);
    chk("clear_idle", {disp[14:0], running}, {15'h0000, 1'b0});

    // partial second is preserved across a pause
    pulse(0);
    step(24);
    chk("run_0003", disp, 16'h0003);
    step(5);
    pulse(0);
    chk("pause2", {disp[14:0], running}, {15'h0003, 1'b0});
    step(100);
    chk("pause_long", disp, 16'h0003);
    pulse(0);
    chk("resume", {15'd0, running}, 16'h0001);
    step(2);
    chk("resume_pre", {disp[14:0], tick}, {15'h0003, 1'b0});
    step(1);
    chk("resume_0004", {disp[14:0], tick}, {15'h0004, 1'b1});

    // lap freeze
    step(8);
    chk("run_0005", disp, 16'h0005);
    pulse(1);
    chk("lap_set", {disp[14:0], frozen}, {15'h0005, LAP});
    step(16);
    chk("lap_hold", disp, LAP ? 16'h0005 : 16'h0007);
    chk("lap_frz", {15'd0, frozen}, {15'd0, LAP});
    pulse(1);
    chk("lap_rel", {disp[14:0], frozen}, {15'h0007, 1'b0});

    pulse(0);
    pulse(2);
    chk("clear2", {disp[14:0], running}, {15'h0000, 1'b0});

    // adjust minutes from IDLE
    adj = 1'b1;
    step(1);
    chk("adj_entry", {disp[11:0], blink_mask}, {12'h000, 4'b1100});
    chk("adj_run", {15'd0, running}, 16'h0000);
    step(1);
    chk("blink_a1", {12'd0, blink_mask}, 16'h000C);
    step(1);
    chk("blink_a2", {disp[11:0], blink_mask}, {12'h000, 4'b0000});
    step(2);
    chk("adj_min1", {disp[11:0], blink_mask}, {12'h100, 4'b1100});
    chk("adj_tick", {15'd0, tick}, 16'h0001);
    step(232);
    chk("adj_min59", disp, 16'h5900);

    // adjust seconds
    sel = 1'b1;
    step(1);
    chk("sel_mask", {12'd0, blink_mask}, 16'h0003);
    step(232);
    chk("adj_sec58", disp, 16'h5958);
    step(4);
    chk("adj_sec59", disp, 16'h5959);
    step(4);
    chk("adj_secwrap", disp, 16'h5900);
    step(236);
    chk("adj_5959", disp, 16'h5959);
    adj = 1'b0;
    step(1);
    chk("adj_exit", {disp[11:0], running, blink_mask[2:0]}, {12'h959, 1'b0, 3'b000});

    // full wrap 59:59 -> 00:00
    pulse(0);
    step(7);
    chk("wrap_pre", {disp[14:0], tick}, {15'h5959 & 15'h7FFF, 1'b0});
    step(1);
    chk("wrap", {disp[13:0], running, tick}, {14'h0000, 1'b1, 1'b1});

    // adj beats start_stop in PAUSE
    pulse(0);
    chk("pause3", {disp[14:0], running}, {15'h0000, 1'b0});
    adj = 1'b1;
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
    chk("prio_adj", {11'd0, running, blink_mask}, {11'd0, 1'b0, 4'b0011});
    adj = 1'b0;
    step(1);
    chk("prio_pause", {disp[14:0], running}, {15'h0000, 1'b0});

    // reset mid-run
    pulse(0);
    step(72);
    chk("run_0009", {disp[14:0], running}, {15'h0009, 1'b1});
    #2 reset = 1'b0;
    #1;
    chk("async_digits", disp, 16'h0000);
    chk("async_flags", {8'd0, running, frozen, tick, 1'b0, blink_mask}, 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
